// File: rtl/sub_serial.sv
// Bit-serial subtractor: computes rb - rc one bit per clock, LSB first, over WIDTH cycles.
// Result and flags update together when the last bit is processed and hold until the next completion.
module sub_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] rb,
    input  logic [WIDTH-1:0] rc,
    output logic [WIDTH-1:0] ra,
    output logic             busy,
    output logic             done,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    // One full-subtractor slice on the current LSBs of the shifting operands.
    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] diff;

    assign bit_d    = a_q[0] ^ b_q[0] ^ bin_q;
    assign bit_bout = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
    assign diff     = (acc_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        acc_d    = acc_q;
        ra_d     = ra_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    a_d      = rb;
                    b_d      = rc;
                    sign_a_d = rb[WIDTH-1];
                    sign_b_d = rc[WIDTH-1];
                    cnt_d    = '0;
                    bin_d    = 1'b0;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                acc_d = diff;
                bin_d = bit_bout;
                cnt_d = cnt_q + 1'b1;
                // The partial result stays internal; outputs only move on the final bit.
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    ra_d     = diff;
                    borrow_d = bit_bout;
                    zero_d   = (diff == '0);
                    ovf_d    = (sign_a_q != sign_b_q) && (bit_d != sign_a_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            acc_q    <= '0;
            ra_q     <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            acc_q    <= acc_d;
            ra_q     <= ra_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ra     = ra_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_sub_serial;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] rb;
    logic [W-1:0] rc;
    logic [W-1:0] ra;
    logic         busy;
    logic         done;
    logic         borrow;
    logic         zero;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] prev_ra = '0;

    sub_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .rb     (rb),
        .rc     (rc),
        .ra     (ra),
        .busy   (busy),
        .done   (done),
        .borrow (borrow),
        .zero   (zero),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] b, input logic [W-1:0] c,
                                  output logic [W-1:0] r, output logic bo,
                                  output logic z, output logic o);
        int ud;
        int sd;
        ud = int'(b) - int'(c);
        sd = int'($signed(b)) - int'($signed(c));
        r  = ud[W-1:0];
        bo = (ud < 0);
        z  = (r == '0);
        o  = (sd > 32767) || (sd < -32768);
    endfunction

    task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] c, input bit perturb);
        logic [W-1:0] er;
        logic         eb, ez, eo;
        int           busy_n, done_n, done_at, ra_moves;
        logic [W-1:0] got_ra;
        logic         got_b, got_z, got_o;
        model(b, c, er, eb, ez, eo);
        busy_n = 0; done_n = 0; done_at = -1; ra_moves = 0;
        got_ra = '0; got_b = 1'b0; got_z = 1'b0; got_o = 1'b0;

        @(negedge clk);
        rb = b; rc = c; start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= W + 2; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = k;
                got_ra = ra; got_b = borrow; got_z = zero; got_o = ovf;
            end
            if (k < W && ra !== prev_ra) ra_moves++;
            if (perturb && k <= W) begin
                start = 1'b1;
                rb = W'($urandom);
                rc = W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;

        check("busy_cycles", busy_n, W);
        check("done_pulses", done_n, 1);
        check("done_latency", done_at, W);
        check("ra_stable_in_run", ra_moves, 0);
        check("ra", got_ra, er);
        check("borrow", got_b, eb);
        check("zero", got_z, ez);
        check("ovf", got_o, eo);
        check("ra_held", ra, er);
        prev_ra = er;
    endtask

    initial begin
        logic [W-1:0] rnd_b, rnd_c;
        rst = 1'b1; start = 1'b0; rb = '0; rc = '0;

        #12;
        check("rst_ra", ra, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", {borrow, zero, ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_start", busy, 0);

        run_op(16'h0005, 16'h0003, 1'b0);
        run_op(16'h0003, 16'h0005, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 1'b0);

        // Abort mid-run with an asynchronous reset.
        @(negedge clk);
        rb = 16'hFFFF; rc = 16'h0001; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_ra", ra, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_flags", {borrow, zero, ovf}, 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 check("rst_beats_start", busy, 0);
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("no_done_after_abort", done, 0);
        check("idle_after_abort", busy, 0);
        prev_ra = '0;

        run_op(16'h000A, 16'h0004, 1'b0);
        run_op(16'h1234, 16'h1234, 1'b1);

        for (int i = 0; i < 24; i++) begin
            rnd_b = W'($urandom);
            case ($urandom_range(0, 5))
                0: rnd_c = rnd_b;
                1: rnd_c = 16'h8000;
                2: rnd_c = 16'h7FFF;
                3: rnd_c = 16'hFFFF;
                default: rnd_c = W'($urandom);
            endcase
            run_op(rnd_b, rnd_c, ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
